// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router packet controller.
package router_pkg;

    localparam int unsigned NUM_PORTS       = 3;
    localparam int unsigned ADDR_W          = 2;
    localparam int unsigned CNT_W           = 5;
    localparam int unsigned TIMEOUT_DEFAULT = 30;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        StDa,
        StLfd,
        StLd,
        StFfs,
        StLaf,
        StLp,
        StCpe,
        StWte
    } state_e;

    function automatic logic [NUM_PORTS-1:0] port_onehot(logic [ADDR_W-1:0] addr);
        logic [NUM_PORTS-1:0] oh;
        oh = '0;
        if (addr != ADDR_INVALID) oh[addr] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/router_pkt_ctrl_if.sv
// Controller-side bundle: source handshake, datapath strobes and per-port FIFO signals.
interface router_pkt_ctrl_if;
    import router_pkg::*;

    logic                  pkt_valid;
    logic [ADDR_W-1:0]     data_in;
    logic                  parity_done;
    logic                  low_pkt_valid;
    logic [NUM_PORTS-1:0]  fifo_full;
    logic [NUM_PORTS-1:0]  fifo_empty;
    logic [NUM_PORTS-1:0]  read_enb;

    logic                  detect_add;
    logic                  lfd_state;
    logic                  ld_state;
    logic                  full_state;
    logic                  laf_state;
    logic                  rst_int_reg;
    logic                  write_enb_reg;
    logic                  busy;
    logic [NUM_PORTS-1:0]  write_enb;
    logic [NUM_PORTS-1:0]  vld_out;
    logic [NUM_PORTS-1:0]  soft_reset;

    modport master (
        input  pkt_valid, data_in, parity_done, low_pkt_valid, fifo_full, fifo_empty, read_enb,
        output detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg,
        output write_enb_reg, busy, write_enb, vld_out, soft_reset
    );

    modport slave (
        output pkt_valid, data_in, parity_done, low_pkt_valid, fifo_full, fifo_empty, read_enb,
        input  detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg,
        input  write_enb_reg, busy, write_enb, vld_out, soft_reset
    );

endinterface

// File: rtl/router_timeout_ctr.sv
// One output port's read-timeout counter with its registered one-cycle soft reset.
module router_timeout_ctr
    import router_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic vld_i,
    input  logic read_i,
    output logic soft_reset_o
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             soft_reset_q, soft_reset_d;
    logic             unread;

    always_comb begin
        unread       = vld_i & ~read_i;
        soft_reset_d = unread && (cnt_q == LastCnt);
        // Restart after firing so a still-stalled port fires again TIMEOUT cycles later.
        cnt_d        = (unread && !soft_reset_d) ? cnt_q + CNT_W'(1) : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q        <= '0;
            soft_reset_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            soft_reset_q <= soft_reset_d;
        end
    end

    assign soft_reset_o = soft_reset_q;

endmodule

// File: rtl/router_pkt_ctrl.sv
// Packet-sequencing FSM for the 1x3 router: header decode, datapath phases, FIFO write
// enables and per-port read-timeout soft resets.
module router_pkt_ctrl
    import router_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    router_pkt_ctrl_if.master  bus
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                addr_ok;
    logic                full_sel;
    logic [NUM_PORTS-1:0] soft_reset;
    logic [NUM_PORTS-1:0] vld_out;

    assign vld_out = ~bus.fifo_empty;

    always_comb begin
        addr_ok  = bus.pkt_valid && (bus.data_in != ADDR_INVALID);
        full_sel = bus.fifo_full[addr_q];
        addr_d   = addr_q;
        state_d  = state_q;

        if (state_q == StDa && addr_ok) addr_d = bus.data_in;

        unique case (state_q)
            StDa: begin
                if (addr_ok) state_d = bus.fifo_empty[bus.data_in] ? StLfd : StWte;
            end
            StWte: if (bus.fifo_empty[addr_q]) state_d = StLfd;
            StLfd: state_d = StLd;
            StLd: begin
                if (full_sel)            state_d = StFfs;
                else if (!bus.pkt_valid) state_d = StLp;
            end
            StFfs: if (!full_sel) state_d = StLaf;
            StLaf: begin
                if (bus.parity_done)        state_d = StDa;
                else if (bus.low_pkt_valid) state_d = StLp;
                else                        state_d = StLd;
            end
            StLp:  state_d = StCpe;
            StCpe: state_d = full_sel ? StFfs : StDa;
            default: state_d = StDa;
        endcase

        // Only a flush of the port currently being written abandons the packet.
        if (state_q != StDa && soft_reset[addr_q]) state_d = StDa;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StDa;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        router_timeout_ctr #(
            .TIMEOUT (TIMEOUT)
        ) u_ctr (
            .clk_i        (clock),
            .rst_i        (reset),
            .vld_i        (vld_out[i]),
            .read_i       (bus.read_enb[i]),
            .soft_reset_o (soft_reset[i])
        );
    end

    assign bus.detect_add    = (state_q == StDa);
    assign bus.lfd_state     = (state_q == StLfd);
    assign bus.ld_state      = (state_q == StLd);
    assign bus.full_state    = (state_q == StFfs);
    assign bus.laf_state     = (state_q == StLaf);
    assign bus.rst_int_reg   = (state_q == StCpe);
    assign bus.write_enb_reg = (state_q == StLd) || (state_q == StLaf) || (state_q == StLp);
    assign bus.busy          = (state_q != StDa) && (state_q != StLd);
    assign bus.write_enb     = bus.write_enb_reg ? port_onehot(addr_q) : '0;
    assign bus.vld_out       = vld_out;
    assign bus.soft_reset    = soft_reset;

endmodule

// File: tb/tb_router_pkt_ctrl.sv
// Scoreboard bench for router_pkt_ctrl: directed stimulus pushes expectations, a negedge
// monitor pops and compares them.
module tb_router_pkt_ctrl;

    localparam int DA = 0, LFD = 1, LD = 2, FFS = 3, LAF = 4, LP = 5, CPE = 6, WTE = 7;
    localparam int KPH = 0, KSR = 1, KVLD = 2;

    typedef struct {
        int          cyc;
        int          kind;
        string       name;
        logic [10:0] val;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_pass;
    exp_t sb[$];

    router_pkt_ctrl_if bus ();

    router_pkt_ctrl #(
        .TIMEOUT (30)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [10:0] phase(int st, int addr);
        logic       wer;
        logic       bsy;
        logic [2:0] we;
        wer = (st == LD) || (st == LAF) || (st == LP);
        bsy = (st == LFD) || (st == FFS) || (st == LAF) || (st == LP) || (st == CPE) || (st == WTE);
        we  = wer ? 3'(1 << addr) : 3'b000;
        return {st == DA, st == LFD, st == LD, st == FFS, st == LAF, st == CPE, wer, bsy, we};
    endfunction

    task automatic push(int kind, string name, logic [10:0] val);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.name = name;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic exp_ph(string name, int st, int addr);
        push(KPH, name, phase(st, addr));
    endtask

    task automatic exp_sr(string name, logic [2:0] v);
        push(KSR, name, {8'b0, v});
    endtask

    task automatic exp_vld(string name, logic [2:0] v);
        push(KVLD, name, {8'b0, v});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [10:0] obs;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            case (e.kind)
                KPH: obs = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.full_state,
                            bus.laf_state, bus.rst_int_reg, bus.write_enb_reg, bus.busy,
                            bus.write_enb};
                KSR:     obs = {8'b0, bus.soft_reset};
                default: obs = {8'b0, bus.vld_out};
            endcase
            n_checks++;
            if (obs === e.val) n_pass++;
            else $display("FAIL %s cyc=%0d got=%b want=%b", e.name, cyc, obs, e.val);
        end
    end

    initial begin
        n_checks          = 0;
        n_pass            = 0;
        rst               = 1'b1;
        bus.pkt_valid     = 1'b0;
        bus.data_in       = 2'd0;
        bus.parity_done   = 1'b0;
        bus.low_pkt_valid = 1'b0;
        bus.fifo_full     = 3'b000;
        bus.fifo_empty    = 3'b111;
        bus.read_enb      = 3'b000;

        // Reset
        step();
        step();
        exp_ph("reset_phase", DA, 0);
        exp_sr("reset_sr", 3'b000);
        rst = 1'b0;
        step();
        exp_ph("post_reset_phase", DA, 0);
        exp_vld("post_reset_vld", 3'b000);

        // Normal packet to port 1
        bus.pkt_valid = 1'b1;
        bus.data_in   = 2'd1;
        step();
        exp_ph("norm_lfd", LFD, 1);
        bus.data_in = 2'd0;
        step();
        exp_ph("norm_ld1", LD, 1);
        step();
        exp_ph("norm_ld2", LD, 1);
        step();
        exp_ph("norm_ld3", LD, 1);
        bus.pkt_valid = 1'b0;
        step();
        exp_ph("norm_lp", LP, 1);
        step();
        exp_ph("norm_cpe", CPE, 1);
        step();
        exp_ph("norm_da", DA, 1);

        // Busy target: port 2 not empty
        bus.fifo_empty = 3'b011;
        bus.read_enb   = 3'b100;
        bus.pkt_valid  = 1'b1;
        bus.data_in    = 2'd2;
        exp_vld("wte_vld", 3'b100);
        step();
        bus.pkt_valid = 1'b0;
        bus.data_in   = 2'd0;
        for (int k = 0; k < 5; k++) begin
            exp_ph("wte_hold", WTE, 2);
            if (k < 4) step();
        end
        bus.fifo_empty = 3'b111;
        bus.read_enb   = 3'b000;
        step();
        exp_ph("wte_lfd", LFD, 2);
        step();
        exp_ph("wte_ld", LD, 2);
        step();
        exp_ph("wte_lp", LP, 2);
        step();
        exp_ph("wte_cpe", CPE, 2);
        step();
        exp_ph("wte_da", DA, 2);

        // Full stall on port 1
        bus.pkt_valid = 1'b1;
        bus.data_in   = 2'd1;
        step();
        exp_ph("full_lfd", LFD, 1);
        step();
        bus.fifo_full = 3'b010;
        exp_ph("full_ld", LD, 1);
        step();
        exp_ph("full_ffs1", FFS, 1);
        step();
        exp_ph("full_ffs2", FFS, 1);
        bus.fifo_full = 3'b000;
        step();
        exp_ph("full_laf", LAF, 1);
        bus.low_pkt_valid = 1'b1;
        bus.pkt_valid     = 1'b0;
        step();
        exp_ph("full_lp", LP, 1);
        bus.low_pkt_valid = 1'b0;
        step();
        exp_ph("full_cpe", CPE, 1);
        step();
        exp_ph("full_da", DA, 1);

        // Invalid address stays in DA
        bus.pkt_valid = 1'b1;
        bus.data_in   = 2'd3;
        step();
        exp_ph("inv_da1", DA, 1);
        step();
        exp_ph("inv_da2", DA, 1);
        bus.pkt_valid = 1'b0;
        bus.data_in   = 2'd0;
        step();

        // Timeout fires after 30 unread cycles
        bus.fifo_empty = 3'b110;
        exp_sr("to_start", 3'b000);
        for (int k = 1; k <= 31; k++) begin
            step();
            exp_sr("to_fire", (k == 30) ? 3'b001 : 3'b000);
        end
        exp_ph("to_fsm_da", DA, 1);
        bus.fifo_empty = 3'b111;
        step();

        // Read at cycle 29 restarts the count
        bus.fifo_empty = 3'b110;
        for (int k = 1; k <= 40; k++) begin
            bus.read_enb = (k == 29) ? 3'b001 : 3'b000;
            step();
            exp_sr("to_read29", 3'b000);
        end
        bus.read_enb   = 3'b000;
        bus.fifo_empty = 3'b111;
        step();

        // Timeout fires mid-packet on port 0
        bus.pkt_valid = 1'b1;
        bus.data_in   = 2'd0;
        step();
        exp_ph("tofsm_lfd", LFD, 0);
        bus.fifo_empty = 3'b110;
        for (int k = 1; k <= 30; k++) begin
            step();
            exp_ph("tofsm_ld", LD, 0);
        end
        exp_sr("tofsm_sr", 3'b001);
        step();
        bus.pkt_valid  = 1'b0;
        bus.fifo_empty = 3'b111;
        exp_ph("tofsm_da", DA, 0);
        exp_sr("tofsm_sr_off", 3'b000);
        step();

        // Reset mid-packet
        bus.pkt_valid = 1'b1;
        bus.data_in   = 2'd2;
        step();
        exp_ph("rmid_lfd", LFD, 2);
        step();
        exp_ph("rmid_ld", LD, 2);
        rst = 1'b1;
        step();
        rst           = 1'b0;
        bus.pkt_valid = 1'b0;
        exp_ph("rmid_da", DA, 0);
        step();
        exp_ph("rmid_idle", DA, 0);

        step();
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
            n_checks += sb.size();
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
